// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : i2c_pkg                                                      |
// | Description : Shared types and constants for the byte-level I2C write      |
// |               engine (FSM states, quarter-bit phases, frame geometry).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package i2c_pkg;

    // Engine states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_ACKSLOT = 3'd3,
        ST_STOP    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Quarter-bit phase indices inside one SCL period.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Frame geometry, counted in quarter-bit ticks or bit slots.
    localparam int START_TICKS   = 2;
    localparam int STOP_TICKS    = 3;
    localparam int BITS_PER_SLOT = 9;
    localparam int TXN_TICKS     = 113;

    // Bit index of the ACK slot and of the last data bit in a byte.
    localparam logic [3:0] ACK_BIT      = 4'(BITS_PER_SLOT - 1);
    localparam logic [3:0] LAST_DATA_BIT = 4'(BITS_PER_SLOT - 2);

    // Index of the final byte (data byte) of the three-byte frame.
    localparam logic [1:0] LAST_BYTE = 2'd2;

    // Select byte idx of the 24-bit command word, byte 0 being the MSB byte.
    function automatic logic [7:0] word_byte(input logic [23:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = word[23:16];
            2'd1:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_tick_gen                                                 |
// | Description : Quarter-bit tick generator. Counts 0..DIV-1 and emits a      |
// |               single-cycle pulse while the count sits at DIV-1.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_tick_gen #(
    parameter int DIV = 625
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iCLR,
    output logic oTICK
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_wrap;

    assign w_wrap = (cnt_q == LAST);

    // Next count: wrap after DIV-1, or restart at zero when a frame begins so
    // the first tick lands exactly DIV cycles after the restart edge.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (iCLR || w_wrap) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oTICK = w_wrap;

endmodule
`default_nettype wire

// File: rtl/i2c_write_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_write_master                                             |
// | Description : Three-byte I2C write engine {slave addr, reg addr, data}.    |
// |               SCL is generated from a quarter-bit tick; SDA is open-drain. |
// |               NACKs are recorded (sticky oACK) but never abort the frame,  |
// |               so every transaction has the same fixed length.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    // System clock cycles per quarter SCL period.
    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

    generate
        if (DIV < 1) begin : g_div_illegal
            $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 1");
        end
        if (START_TICKS + 3 * BITS_PER_SLOT * 4 + STOP_TICKS != TXN_TICKS) begin : g_txn_len_illegal
            $error("i2c_write_master: frame geometry does not add up to TXN_TICKS");
        end
    endgenerate

    state_t      state_q,   state_d;
    logic [1:0]  quarter_q, quarter_d;   // quarter within a bit, or tick within START/STOP
    logic [3:0]  bit_q,     bit_d;       // 0..7 data bits, 8 = ACK slot
    logic [1:0]  byte_q,    byte_d;      // 0..2 byte of the frame
    logic [23:0] data_q,    data_d;      // command word latched at accept
    logic        ack_q,     ack_d;       // sticky NACK flag
    logic        end_q,     end_d;       // idle/complete flag
    logic        armed_q,   armed_d;     // iGO has been seen low since the last accept

    logic        w_tick;
    logic        w_accept;
    logic        w_scl;
    logic        w_sda_low;
    logic [7:0]  w_cur_byte;

    // A request is taken only from IDLE and only once per low-to-high of iGO.
    assign w_accept   = (state_q == ST_IDLE) && iGO && armed_q;
    assign w_cur_byte = word_byte(data_q, byte_q);

    i2c_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iCLR  (w_accept),
        .oTICK (w_tick)
    );

    // State register: all FSM state, counters and status flags.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            quarter_q <= Q0;
            bit_q     <= 4'd0;
            byte_q    <= 2'd0;
            data_q    <= 24'd0;
            ack_q     <= 1'b0;
            end_q     <= 1'b1;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            end_q     <= end_d;
            armed_q   <= armed_d;
        end
    end

    // Next-state logic: advance through START, 27 bit slots and STOP on ticks.
    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        data_d    = data_q;
        ack_d     = ack_q;
        end_d     = end_q;
        armed_d   = armed_q;

        case (state_q)
            ST_IDLE: begin
                if (!iGO) begin
                    armed_d = 1'b1;
                end
                if (w_accept) begin
                    data_d    = iDATA;
                    ack_d     = 1'b0;
                    armed_d   = 1'b0;
                    end_d     = 1'b0;
                    quarter_d = Q0;
                    bit_d     = 4'd0;
                    byte_d    = 2'd0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (quarter_q == 2'(START_TICKS - 1)) begin
                        quarter_d = Q0;
                        bit_d     = 4'd0;
                        byte_d    = 2'd0;
                        state_d   = ST_DATA;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == Q3) begin
                        if (bit_q == LAST_DATA_BIT) begin
                            bit_d   = ACK_BIT;
                            state_d = ST_ACKSLOT;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end

            ST_ACKSLOT: begin
                if (w_tick) begin
                    quarter_d = quarter_q + 2'd1;
                    // SCL has been high for a full quarter here: sample the slave.
                    if ((quarter_q == Q1) && (I2C_SDAT == 1'b1)) begin
                        ack_d = 1'b1;
                    end
                    if (quarter_q == Q3) begin
                        if (byte_q == LAST_BYTE) begin
                            quarter_d = Q0;
                            state_d   = ST_STOP;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 4'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    if (quarter_q == 2'(STOP_TICKS - 1)) begin
                        quarter_d = Q0;
                        state_d   = ST_DONE;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end

            ST_DONE: begin
                end_d   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs: SCL high in Q1/Q2 of each bit; SDA pulled low or released.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (state_q)
            ST_START: begin
                w_sda_low = (quarter_q == Q1);
            end
            ST_DATA: begin
                w_scl     = (quarter_q == Q1) || (quarter_q == Q2);
                w_sda_low = ~w_cur_byte[3'd7 - bit_q[2:0]];
            end
            ST_ACKSLOT: begin
                w_scl     = (quarter_q == Q1) || (quarter_q == Q2);
                w_sda_low = 1'b0;
            end
            ST_STOP: begin
                w_scl     = (quarter_q != Q0);
                w_sda_low = (quarter_q != Q2);
            end
            default: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
        endcase
    end

    assign I2C_SCLK = w_scl;
    assign I2C_SDAT = w_sda_low ? 1'b0 : 1'bz;
    assign oEND     = end_q;
    assign oBUSY    = ~end_q;
    assign oACK     = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_master.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_write_master                                          |
// | Description : Bench for i2c_write_master. A bus-level monitor decodes      |
// |               START/STOP and the bits sampled on SCL rising edges; a       |
// |               slave model ACKs or NACKs each byte from a per-frame mask.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_i2c_write_master;

    localparam int CLK_FREQ  = 1600;
    localparam int I2C_FREQ  = 100;
    localparam int DIV       = CLK_FREQ / (4 * I2C_FREQ);   // 4
    localparam int TXN_TICKS = 2 + 3 * 9 * 4 + 3;           // 113
    localparam int LAT       = TXN_TICKS * DIV + 1;         // 453
    localparam int LAT_FAST  = TXN_TICKS * 1 + 1;           // 114

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data = 24'd0;
    logic        go = 1'b0;
    logic        end_o, ack_o, busy_o, scl;
    wire         sda;
    logic        slave_low = 1'b0;
    logic [2:0]  nack_mask = 3'b000;

    logic [23:0] data2 = 24'd0;
    logic        go2 = 1'b0;
    logic        end2, ack2, busy2, scl2;
    wire         sda2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pullup (sda);
    pullup (sda2);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_write_master #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iDATA    (data),
        .iGO      (go),
        .oEND     (end_o),
        .oACK     (ack_o),
        .oBUSY    (busy_o),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    i2c_write_master #(
        .CLK_FREQ (400),
        .I2C_FREQ (100)
    ) u_fast (
        .iCLK     (clk),
        .iRST     (rst),
        .iDATA    (data2),
        .iGO      (go2),
        .oEND     (end2),
        .oACK     (ack2),
        .oBUSY    (busy2),
        .I2C_SCLK (scl2),
        .I2C_SDAT (sda2)
    );

    // Bus monitor + slave model for the main instance.
    logic p_scl = 1'b1, p_sda = 1'b1;
    int   n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0;
    logic rise_sda [64];

    always @(negedge clk) begin
        p_scl <= scl;
        p_sda <= sda;
        if (rst) slave_low <= 1'b0;
        if (p_scl && scl && (sda !== p_sda)) begin
            if (sda === 1'b0) begin
                n_start   <= n_start + 1;
                n_rise    <= 0;
                n_fall    <= 0;
                slave_low <= 1'b0;
            end else begin
                n_stop <= n_stop + 1;
            end
        end
        if (!p_scl && scl) begin
            if (n_rise < 64) rise_sda[n_rise] <= sda;
            n_rise <= n_rise + 1;
        end
        if (p_scl && !scl) begin
            n_fall <= n_fall + 1;
            // Fall #1 enters bit slot 0; slot s ends with fall #(s+2).
            for (int b = 0; b < 3; b++) begin
                if (n_fall + 1 == 9 * b + 9)  slave_low <= !nack_mask[b];
                if (n_fall + 1 == 9 * b + 10) slave_low <= 1'b0;
            end
        end
    end

    // Bus monitor for the DIV=1 instance: SDA changes while SCL is held high.
    logic p_scl2 = 1'b1, p_sda2 = 1'b1;
    int   hi_chg2 = 0, n_rise2 = 0;

    always @(negedge clk) begin
        p_scl2 <= scl2;
        p_sda2 <= sda2;
        if (p_scl2 && scl2 && (sda2 !== p_sda2)) hi_chg2 <= hi_chg2 + 1;
        if (!p_scl2 && scl2) n_rise2 <= n_rise2 + 1;
    end

    task automatic wait_done(input logic [23:0] d, input logic [2:0] nm,
                             input int s0, input int p0, input string tag);
        int         cyc;
        logic [7:0] got, expb;
        cyc = 0;
        while (end_o !== 1'b1 && cyc <= 2 * LAT) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, cyc, LAT);
        end
        n_vec++;
        if (ack_o !== (|nm)) begin
            n_err++;
            $display("FAIL %s oACK: got %b, want %b", tag, ack_o, |nm);
        end
        n_vec++;
        if (n_start - s0 != 1) begin
            n_err++;
            $display("FAIL %s start count: got %0d, want 1", tag, n_start - s0);
        end
        n_vec++;
        if (n_stop - p0 != 1) begin
            n_err++;
            $display("FAIL %s stop count: got %0d, want 1", tag, n_stop - p0);
        end
        n_vec++;
        if (n_rise != 28) begin
            n_err++;
            $display("FAIL %s SCL rises: got %0d, want 28", tag, n_rise);
        end
        for (int b = 0; b < 3; b++) begin
            got = 8'd0;
            for (int k = 0; k < 8; k++) got = {got[6:0], rise_sda[9 * b + k]};
            expb = 8'(d >> (16 - 8 * b));
            n_vec++;
            if (got !== expb) begin
                n_err++;
                $display("FAIL %s byte%0d: got %h, want %h", tag, b, got, expb);
            end
            n_vec++;
            if (rise_sda[9 * b + 8] !== nm[b]) begin
                n_err++;
                $display("FAIL %s ackslot%0d SDA: got %b, want %b", tag, b, rise_sda[9 * b + 8], nm[b]);
            end
        end
        n_vec++;
        if (rise_sda[27] !== 1'b0) begin
            n_err++;
            $display("FAIL %s stop SDA at SCL rise: got %b, want 0", tag, rise_sda[27]);
        end
    endtask

    task automatic do_txn(input logic [23:0] d, input logic [2:0] nm, input string tag);
        int s0, p0;
        data      = d;
        nack_mask = nm;
        s0        = n_start;
        p0        = n_stop;
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (end_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: oEND=%b oBUSY=%b, want 0/1", tag, end_o, busy_o);
        end
        wait_done(d, nm, s0, p0, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; go2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (end_o !== 1'b1 || busy_o !== 1'b0 || ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset status: oEND=%b oBUSY=%b oACK=%b, want 1/0/0", end_o, busy_o, ack_o);
        end
        n_vec++;
        if (scl !== 1'b1 || sda !== 1'b1) begin
            n_err++;
            $display("FAIL reset bus: SCL=%b SDA=%b, want 1/1", scl, sda);
        end
        n_vec++;
        if (end2 !== 1'b1 || scl2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset fast: oEND=%b SCL=%b, want 1/1", end2, scl2);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        do_txn(24'h729803, 3'b000, "nominal");
        @(negedge clk); go = 1'b0;
    endtask

    task automatic test_addr_nack();
        do_txn(24'h7201FF, 3'b001, "addr_nack");
        @(negedge clk); go = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [23:0] d;
            logic [2:0]  nm;
            d  = 24'($urandom);
            nm = 3'($urandom_range(0, 7));
            do_txn(d, nm, $sformatf("random%0d", t));
            @(negedge clk); go = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
    endtask

    task automatic test_rearm();
        int s0, low;
        do_txn(24'($urandom), 3'b100, "rearm_first");
        s0  = n_start;
        low = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (end_o !== 1'b1) low++;
        end
        n_vec++;
        if (low != 0) begin
            n_err++;
            $display("FAIL rearm held-go busy cycles: got %0d, want 0", low);
        end
        n_vec++;
        if (n_start != s0) begin
            n_err++;
            $display("FAIL rearm held-go starts: got %0d, want 0", n_start - s0);
        end
        n_vec++;
        if (ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL rearm oACK hold: got %b, want 1", ack_o);
        end
        @(negedge clk); go = 1'b0;
        do_txn(24'h72AF16, 3'b000, "rearm_second");
        @(negedge clk); go = 1'b0;
    endtask

    task automatic test_mid_reset();
        int          s0, p0, guard;
        logic [23:0] d2;
        data      = 24'($urandom);
        nack_mask = 3'b001;
        s0        = n_start;
        @(negedge clk); go = 1'b1;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!(n_start > s0 && n_rise >= 13) && guard < 2 * LAT);
        #1;
        n_vec++;
        if (guard >= 2 * LAT) begin
            n_err++;
            $display("FAIL mid_reset wait for byte1 bit3: got timeout, want slot reached");
        end
        n_vec++;
        if (ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset oACK before reset: got %b, want 1", ack_o);
        end
        @(negedge clk); rst = 1'b1;
        #1;
        n_vec++;
        if (scl !== 1'b1 || sda !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset bus: SCL=%b SDA=%b, want 1/1", scl, sda);
        end
        n_vec++;
        if (end_o !== 1'b1 || ack_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset status: oEND=%b oACK=%b oBUSY=%b, want 1/0/0", end_o, ack_o, busy_o);
        end
        d2        = 24'($urandom);
        data      = d2;
        nack_mask = 3'b000;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (end_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset accept at release: oEND=%b, want 0", end_o);
        end
        s0 = n_start;
        p0 = n_stop;
        wait_done(d2, 3'b000, s0, p0, "post_reset");
        @(negedge clk); go = 1'b0;
    endtask

    task automatic test_fast();
        for (int t = 0; t < 2; t++) begin
            int cyc, h0, r0;
            data2 = 24'($urandom);
            @(negedge clk); go2 = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (end2 !== 1'b0) begin
                n_err++;
                $display("FAIL fast%0d accept: oEND=%b, want 0", t, end2);
            end
            h0  = hi_chg2;
            r0  = n_rise2;
            cyc = 0;
            while (end2 !== 1'b1 && cyc <= 2 * LAT_FAST) begin
                @(posedge clk); #1;
                cyc++;
            end
            n_vec++;
            if (cyc != LAT_FAST) begin
                n_err++;
                $display("FAIL fast%0d latency: got %0d, want %0d", t, cyc, LAT_FAST);
            end
            n_vec++;
            if (ack2 !== 1'b1) begin
                n_err++;
                $display("FAIL fast%0d oACK (no slave): got %b, want 1", t, ack2);
            end
            n_vec++;
            if (hi_chg2 - h0 != 2) begin
                n_err++;
                $display("FAIL fast%0d SDA edges while SCL high: got %0d, want 2", t, hi_chg2 - h0);
            end
            n_vec++;
            if (n_rise2 - r0 != 28) begin
                n_err++;
                $display("FAIL fast%0d SCL rises: got %0d, want 28", t, n_rise2 - r0);
            end
            @(negedge clk); go2 = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_addr_nack();
        test_random();
        test_rearm();
        test_mid_reset();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
